// File: rtl/rvfi_commit_serializer.sv
// RVFI commit serializer: turns the core's multi-port retirement bundle into
// a single in-order record stream. The core cannot stall. When a record does
// not fit in the FIFO it is dropped, and every drop is counted.
//
// Handshake: a record transfers on any cycle where valid_o && ready_i.
// valid_o, rvfi_o and seq_o come only from registered state, so they hold
// steady while valid_o && !ready_i. ready_i while !valid_o is ignored.

package rvfi_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [4:0]  rd_addr;
    logic [63:0] rd_wdata;
    logic [63:0] pc_rdata;
    logic [63:0] pc_wdata;
    logic [63:0] mem_addr;
  } rvfi_instr_t;
endpackage

module rvfi_commit_serializer #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
  output rvfi_pkg::rvfi_instr_t                     rvfi_o,
  output logic                                      valid_o,
  input  logic                                      ready_i,
  output logic [63:0]                               seq_o,
  output logic [$clog2(DEPTH):0]                    count_o,
  output logic                                      overflow_o,
  output logic [31:0]                               dropped_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rvfi_pkg::rvfi_instr_t mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [63:0]      seq;
  logic             overflow;
  logic [31:0]      dropped;

  logic                       pop;
  logic [CNT_W-1:0]           free_slots;
  logic [CNT_W-1:0]           push_n;
  logic [CNT_W-1:0]           drop_n;
  logic [NR_COMMIT_PORTS-1:0] we;
  logic [PTR_W-1:0]           slot [NR_COMMIT_PORTS];
  logic [32:0]                drop_sum;
  logic [31:0]                dropped_next;

  assign pop = valid_o && ready_i;

  // Pack qualifying ports, oldest first, into the free slots; the rest drop.
  always_comb begin
    free_slots = CNT_W'(DEPTH) - count + CNT_W'(pop);
    push_n     = '0;
    drop_n     = '0;
    we         = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      slot[i] = wr_ptr + PTR_W'(push_n);
      if (rvfi_i[i].valid || rvfi_i[i].trap) begin
        if (push_n < free_slots) begin
          we[i]  = 1'b1;
          push_n = push_n + CNT_W'(1);
        end else begin
          drop_n = drop_n + CNT_W'(1);
        end
      end
    end
  end

  // Drop counter saturates instead of wrapping.
  always_comb begin
    drop_sum     = {1'b0, dropped} + 33'(drop_n);
    dropped_next = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
  end

  // Pointer, occupancy, sequence and drop bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PTR_W'(pop);
      wr_ptr  <= wr_ptr + PTR_W'(push_n);
      count   <= count + push_n - CNT_W'(pop);
      seq     <= seq + 64'(pop);
      dropped <= dropped_next;
      if (drop_n != '0) begin
        overflow <= 1'b1;
      end
    end
  end

  // Record storage. It has no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (we[i]) begin
          mem[slot[i]] <= rvfi_i[i];
        end
      end
    end
  end

  assign valid_o    = (count != '0);
  assign rvfi_o     = valid_o ? mem[rd_ptr] : '0;
  assign seq_o      = seq;
  assign count_o    = count;
  assign overflow_o = overflow;
  assign dropped_o  = dropped;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Bench for rvfi_commit_serializer.
// A hand-derived vector table covers the directed scenarios. A random phase
// follows. Every cycle is also checked against a queue-based reference model.

module tb_rvfi_commit_serializer;

  localparam int DEPTH = 8;
  localparam int REC_W = $bits(rvfi_pkg::rvfi_instr_t);

  logic                        clk;
  logic                        rst;
  rvfi_pkg::rvfi_instr_t [1:0] rvfi_in;
  rvfi_pkg::rvfi_instr_t       rvfi_out;
  logic                        valid;
  logic                        ready;
  logic [63:0]                 seq;
  logic [3:0]                  count;
  logic                        overflow;
  logic [31:0]                 dropped;

  rvfi_commit_serializer #(.NR_COMMIT_PORTS(2), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rvfi_i     (rvfi_in),
    .rvfi_o     (rvfi_out),
    .valid_o    (valid),
    .ready_i    (ready),
    .seq_o      (seq),
    .count_o    (count),
    .overflow_o (overflow),
    .dropped_o  (dropped)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] ord_ctr = '0;

  logic [REC_W-1:0] exp_q[$];
  logic [63:0]      m_seq  = '0;
  logic [31:0]      m_drop = '0;
  logic             m_ovf  = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // kind bit0 = valid, bit1 = trap
  function automatic rvfi_pkg::rvfi_instr_t make_rec(input int kind, input logic [63:0] pc,
                                                     input bit rnd);
    rvfi_pkg::rvfi_instr_t r;
    r          = '0;
    r.valid    = kind[0];
    r.trap     = kind[1];
    r.pc_rdata = pc;
    r.pc_wdata = pc + 64'd4;
    r.order    = ord_ctr;
    ord_ctr    = ord_ctr + 64'd1;
    if (rnd) begin
      r.insn     = $urandom;
      r.rd_addr  = 5'($urandom_range(0, 31));
      r.rd_wdata = {$urandom, $urandom};
      r.mem_addr = {$urandom, $urandom};
      r.mode     = 2'($urandom_range(0, 3));
      r.intr     = 1'($urandom_range(0, 1));
    end else begin
      r.insn     = pc[31:0] ^ 32'h0000_0013;
    end
    return r;
  endfunction

  // Reference model: a queue of at most DEPTH records. The head leaves first.
  // Then each qualifying port, in order, is stored if there is room or is
  // counted as dropped.
  task automatic model_update(input logic r, input logic rdy, input rvfi_pkg::rvfi_instr_t p0,
                              input rvfi_pkg::rvfi_instr_t p1);
    rvfi_pkg::rvfi_instr_t ports [2];
    ports[0] = p0;
    ports[1] = p1;
    if (r) begin
      exp_q.delete();
      m_seq  = '0;
      m_drop = '0;
      m_ovf  = 1'b0;
    end else begin
      if (rdy && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        m_seq = m_seq + 64'd1;
      end
      for (int i = 0; i < 2; i++) begin
        if (ports[i].valid || ports[i].trap) begin
          if (exp_q.size() < DEPTH) begin
            exp_q.push_back(ports[i]);
          end else begin
            if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_check();
    logic [REC_W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("m_valid", valid, exp_q.size() != 0);
    chk("m_rvfi", rvfi_out, head);
    chk("m_seq", seq, m_seq);
    chk("m_count", count, exp_q.size());
    chk("m_overflow", overflow, m_ovf);
    chk("m_dropped", dropped, m_drop);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic rdy, input rvfi_pkg::rvfi_instr_t p0,
                      input rvfi_pkg::rvfi_instr_t p1);
    @(negedge clk);
    rst        = r;
    ready      = rdy;
    rvfi_in[0] = p0;
    rvfi_in[1] = p1;
    @(posedge clk);
    model_update(r, rdy, p0, p1);
    #1;
    model_check();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        ready;
    int          k0;
    logic [63:0] pc0;
    int          k1;
    logic [63:0] pc1;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_seq;
    int          e_count;
    int          e_dropped;
    logic        e_ovf;
    logic        e_trap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input int k0, input logic [63:0] pc0,
                     input int k1, input logic [63:0] pc1, input logic ev,
                     input logic [63:0] epc, input logic [63:0] eseq, input int ecnt,
                     input int edrop, input logic eovf, input logic etrap);
    vec_t v;
    v = '{r, rdy, k0, pc0, k1, pc1, ev, epc, eseq, ecnt, edrop, eovf, etrap};
    vecs.push_back(v);
  endtask

  initial begin
    rst     = 1'b1;
    ready   = 1'b0;
    rvfi_in = '0;

    // Reset held two cycles with both ports committing.
    add(1, 1, 1, 64'h10, 1, 64'h14, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 64'h18, 1, 64'h1c, 0, 0, 0, 0, 0, 0, 0);
    // Dual commit ordering.
    add(0, 1, 1, 64'h8000_0000, 1, 64'h8000_0004, 1, 64'h8000_0000, 0, 2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 64'h8000_0004, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    // Port 0 idle, port 1 trap only.
    add(0, 1, 0, 0, 2, 64'h100, 1, 64'h100, 2, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    // Fresh reset, then backpressure with 10 records into 8 slots.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 1, 64'h1000 + 64'(8*k), 1, 64'h1004 + 64'(8*k), 1, 64'h1000, 0,
          (2*k+2 > 8) ? 8 : 2*k+2, (k == 4) ? 2 : 0, k == 4, 0);
    // Drain: the first 8 records come out in order.
    for (int k = 1; k <= 8; k++)
      add(0, 1, 0, 0, 0, 0, k < 8, (k < 8) ? 64'h1000 + 64'(4*k) : 64'h0, 64'(k), 8 - k, 2, 1, 0);
    // Refill to full.
    for (int k = 0; k < 4; k++)
      add(0, 0, 1, 64'h3000 + 64'(8*k), 1, 64'h3004 + 64'(8*k), 1, 64'h3000, 8, 2*k+2, 2, 1, 0);
    // Full, pop and dual commit in the same cycle: port 0 kept, port 1 dropped.
    add(0, 1, 1, 64'h4000, 1, 64'h4004, 1, 64'h3004, 9, 8, 3, 1, 0);
    for (int j = 1; j <= 8; j++)
      add(0, 1, 0, 0, 0, 0, j < 8,
          (j < 7) ? 64'h3004 + 64'(4*j) : ((j == 7) ? 64'h4000 : 64'h0),
          64'(9 + j), 8 - j, 3, 1, 0);
    // Reset mid-stream with 4 records buffered.
    add(0, 0, 1, 64'h5000, 1, 64'h5004, 1, 64'h5000, 17, 2, 3, 1, 0);
    add(0, 0, 1, 64'h5008, 1, 64'h500c, 1, 64'h5000, 17, 4, 3, 1, 0);
    add(1, 0, 1, 64'h6000, 1, 64'h6004, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 64'h200, 0, 0, 1, 64'h200, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Apply the table.
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      step(v.rst, v.ready, make_rec(v.k0, v.pc0, 1'b0), make_rec(v.k1, v.pc1, 1'b0));
      chk($sformatf("v%0d_valid", i), valid, v.e_valid);
      chk($sformatf("v%0d_pc", i), rvfi_out.pc_rdata, v.e_pc);
      chk($sformatf("v%0d_seq", i), seq, v.e_seq);
      chk($sformatf("v%0d_count", i), count, v.e_count);
      chk($sformatf("v%0d_dropped", i), dropped, v.e_dropped);
      chk($sformatf("v%0d_overflow", i), overflow, v.e_ovf);
      chk($sformatf("v%0d_trap", i), rvfi_out.trap, v.e_trap);
    end

    // Random phase, checked against the model only.
    for (int c = 0; c < 1500; c++) begin
      logic r;
      logic rdy;
      int   k0;
      int   k1;
      r   = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 99) < 60);
      k0  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3));
      k1  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3));
      step(r, rdy, make_rec(k0, {$urandom, $urandom}, 1'b1), make_rec(k1, {$urandom, $urandom}, 1'b1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_serializer.md
# rvfi_commit_serializer

Converts the multi-port RVFI commit bundle emitted by the core into a single in-order record stream with a valid/ready handshake. It sits between the core's RVFI output and per-hart trace, logging and checking consumers. Those consumers can then process one retired instruction or trap per cycle and apply backpressure. The core cannot be stalled, so records that do not fit are dropped and counted.

## Interface
- NR_COMMIT_PORTS, 2: commit ports in `rvfi_i`. Port 0 is always the oldest.
- DEPTH, 8: FIFO entries. Power of two, ≥ NR_COMMIT_PORTS.
- clk_i  in  1  clock; all logic is on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- rvfi_i  in  rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]  commit records from the core
- rvfi_o  out  rvfi_pkg::rvfi_instr_t  head record; all zeros when empty
- valid_o  out  1  head record is valid
- ready_i  in  1  consumer accepts the head this cycle
- seq_o  out  64  index of the head record in the accepted stream, counted from 0 after reset
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow_o  out  1  sticky: at least one record has been dropped since reset
- dropped_o  out  32  number of dropped records, saturating at 32'hFFFF_FFFF

## Operation
- **Record qualifies:** `rvfi_i[i].valid || rvfi_i[i].trap`. Non-qualifying ports are ignored, including gaps such as port 0 idle with port 1 valid.
- **Push order:** qualifying records are written in ascending port index into consecutive slots from the write pointer. The record is stored unmodified.
- **Pop:** occurs when `valid_o && ready_i`. The read pointer and `seq_o` advance by 1.
- **Free space for the cycle:** `DEPTH - count + pop`. A slot freed by a same-cycle pop is reusable.
- **Overflow:** if qualifying records exceed free space, the oldest (lowest-port) records that fit are stored. The remainder are dropped.
  - `dropped_o` increases by the number dropped.
  - `overflow_o` is set and stays set until reset.
- **Storage:** circular buffer with wrapping read/write pointers of width $clog2(DEPTH).
- **Occupancy:** `count` next = `count + pushed - pop`. `count_o` reaches DEPTH when full.
- **Head output:**
  - `valid_o = (count != 0)`.
  - `rvfi_o = mem[rd_ptr]` when valid, else '0.
  - `seq_o` increments per pop and wraps modulo 2^64.
- **Reset:**
  - Pointers, count, `seq_o`, `overflow_o` and `dropped_o` go to 0.
  - `valid_o` is 0 and `rvfi_o` is '0.
  - FIFO contents are discarded.
  - Records presented during a reset cycle are neither stored nor counted as dropped.
- **Reset mid-stream:** all buffered records are lost. The first post-reset record gets `seq_o` = 0.
- `ready_i` while `valid_o` = 0 has no effect.
- `rvfi_o` and `seq_o` must hold stable while `valid_o && !ready_i`.

## Timing
- **Latency:** a record presented in cycle N is visible on `rvfi_o`/`valid_o` in cycle N+1 at the earliest, when the FIFO was empty or was popped down to it. There is no combinational path from `rvfi_i` to any output.
- **No combinational path from `ready_i`:** all outputs are registered or decoded from registered state.
- **Throughput:** 1 record out per cycle. Input burst rate is up to NR_COMMIT_PORTS per cycle, limited by DEPTH.
- **Same-cycle update:** `overflow_o` and `dropped_o` update in cycle N+1 for drops in cycle N.
- **Simultaneous push and pop while full:** with `count` = DEPTH, 1 pop and 2 qualifying records, 1 record is stored, 1 is dropped and `count` stays DEPTH.

## Test plan
- **Reset:** assert `rst_i` 2 cycles with both ports valid → all outputs zero, `count_o` = 0, nothing stored after deassert.
- **Dual commit, ordering:** cycle 0 drive port0 pc=0x80000000, port1 pc=0x80000004, `ready_i` = 1.
  - → cycle 1: `rvfi_o.pc_rdata` = 0x80000000, `seq_o` = 0.
  - → cycle 2: 0x80000004, `seq_o` = 1.
  - → cycle 3: `valid_o` = 0.
- **Gap and trap:** port0 idle, port1 trap=1, pc=0x100 → one record out with trap=1, `count_o` peaks at 1.
- **Backpressure and overflow:** DEPTH = 8, `ready_i` = 0, 5 cycles of dual commits (10 records).
  - → `count_o` = 8, `dropped_o` = 2, `overflow_o` = 1.
  - → draining yields the first 8 records in order, `seq_o` 0..7.
- **Full with simultaneous pop:** `count_o` = 8, `ready_i` = 1, dual commit → `count_o` stays 8, `dropped_o` +1, the port0 record is stored.
- **Reset mid-stream:** 4 records buffered, pulse `rst_i` 1 cycle, then one commit pc=0x200.
  - → only 0x200 is emitted, with `seq_o` = 0.
  - → `dropped_o` = 0.
